// File: rtl/life_ctrl.sv
// Game-of-life controller: run/pause/setting FSM, evolution pacing,
// ping-pong buffer bookkeeping and the cell-editing cursor.
module life_ctrl #(
  parameter int COLS        = 800,
  parameter int ROWS        = 600,
  parameter int ADDR_W      = 24,
  parameter int BASE_PERIOD = 5000000,
  parameter int GEN_W       = 16,
  parameter int WRAP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              clear,
  input  logic              step,
  input  logic              toggle,
  input  logic              speed_up,
  input  logic              speed_dn,
  input  logic              manual,
  input  logic [3:0]        dir,
  input  logic              init_done,
  input  logic              evo_done,
  output logic [1:0]        state,
  output logic              evo_req,
  output logic              init_req,
  output logic              buf_sel,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count,
  output logic [1:0]        speed,
  output logic              overrun,
  output logic [11:0]       cursor_x,
  output logic [11:0]       cursor_y,
  output logic [ADDR_W-1:0] cursor_pos,
  output logic              toggle_req,
  output logic [ADDR_W-1:0] toggle_pos
);
  typedef enum logic [1:0] {S_RST = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_SET = 2'd3} state_t;

  localparam int CNT_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GEN_W-1:0]  GEN_ONE  = GEN_W'(1);
  localparam logic [11:0]       X_MAX    = 12'(COLS - 1);
  localparam logic [11:0]       Y_MAX    = 12'(ROWS - 1);
  localparam logic [11:0]       X_MID    = 12'(COLS / 2);
  localparam logic [11:0]       Y_MID    = 12'(ROWS / 2);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] X_SPAN   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] Y_SPAN   = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] POS_MID  = ADDR_W'((ROWS / 2) * COLS + COLS / 2);
  localparam bit                WRAP_EN  = (WRAP != 0);

  state_t           st, prev;
  logic [CNT_W-1:0] cnt, limit;
  logic [31:0]      per;
  logic             init_pending;
  logic             tick, do_clear, go_evo, set_ovr, evo_ok;
  logic             spd_inc, spd_dec;
  logic             in_set;

  assign state  = st;
  assign in_set = (st == S_SET);

  // Tick limit for the current speed; a period that shifts down to 0 acts as 1.
  always_comb begin
    per   = 32'(BASE_PERIOD) >> speed;
    limit = (per == 32'd0) ? '0 : CNT_W'(per - 32'd1);
  end

  assign tick     = (st == S_RUN) && (cnt == limit);
  assign do_clear = clear && !in_set;
  assign go_evo   = !busy && !clear && !pause &&
                    (((st == S_PAUSE) && !manual && !start && step) || ((st == S_RUN) && tick));
  assign set_ovr  = busy && !clear && !pause && (st == S_RUN) && tick;
  assign evo_ok   = evo_done && busy;
  assign spd_inc  = speed_up && !speed_dn && (speed != 2'd3);
  assign spd_dec  = speed_dn && !speed_up && (speed != 2'd0);

  // Control FSM, pacing counter, evolution and init handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_RST;
      prev         <= S_RST;
      evo_req      <= 1'b0;
      init_req     <= 1'b0;
      init_pending <= 1'b1;
      busy         <= 1'b0;
      buf_sel      <= 1'b0;
      gen_count    <= '0;
      speed        <= 2'd0;
      overrun      <= 1'b0;
      cnt          <= '0;
    end else begin
      evo_req  <= go_evo;
      init_req <= 1'b0;

      if (do_clear) st <= S_RST;
      else begin
        case (st)
          S_RST:   if (manual) begin st <= S_SET; prev <= S_RST; end
                   else if (start && init_done) st <= S_PAUSE;
          S_PAUSE: if (manual) begin st <= S_SET; prev <= S_PAUSE; end
                   else if (start && !pause) st <= S_RUN;
          S_RUN:   if (pause) st <= S_PAUSE;
          S_SET:   if (!manual) st <= prev;
          default: st <= S_RST;
        endcase
      end

      if (spd_inc)      speed <= speed + 2'd1;
      else if (spd_dec) speed <= speed - 2'd1;

      if (do_clear || spd_inc || spd_dec) cnt <= '0;
      else if (st == S_RUN)               cnt <= tick ? '0 : cnt + CNT_ONE;

      if (go_evo)      busy <= 1'b1;
      else if (evo_ok) busy <= 1'b0;

      // A generation finishing after a clear is stale: drop it so the
      // freshly cleared buffer/count are not disturbed.
      if (do_clear) begin
        buf_sel   <= 1'b0;
        gen_count <= '0;
      end else if (evo_ok && !init_pending) begin
        buf_sel   <= ~buf_sel;
        gen_count <= gen_count + GEN_ONE;
      end

      if (do_clear)     overrun <= 1'b0;
      else if (set_ovr) overrun <= 1'b1;

      // Init waits for the engine to go idle so it never races a generation.
      if (do_clear) init_pending <= 1'b1;
      else if (init_pending && !busy) begin
        init_req     <= 1'b1;
        init_pending <= 1'b0;
      end
    end
  end

  // Cursor movement and cell-toggle requests, active only while setting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_x   <= X_MID;
      cursor_y   <= Y_MID;
      cursor_pos <= POS_MID;
      toggle_req <= 1'b0;
      toggle_pos <= '0;
    end else begin
      toggle_req <= in_set && toggle;
      if (in_set && toggle) toggle_pos <= cursor_pos;
      if (in_set) begin
        case (dir)
          4'b0001: if (cursor_x != 12'd0) begin
                     cursor_x <= cursor_x - 12'd1; cursor_pos <= cursor_pos - A_ONE;
                   end else if (WRAP_EN) begin
                     cursor_x <= X_MAX; cursor_pos <= cursor_pos + X_SPAN;
                   end
          4'b0010: if (cursor_y != 12'd0) begin
                     cursor_y <= cursor_y - 12'd1; cursor_pos <= cursor_pos - STRIDE;
                   end else if (WRAP_EN) begin
                     cursor_y <= Y_MAX; cursor_pos <= cursor_pos + Y_SPAN;
                   end
          4'b0100: if (cursor_y != Y_MAX) begin
                     cursor_y <= cursor_y + 12'd1; cursor_pos <= cursor_pos + STRIDE;
                   end else if (WRAP_EN) begin
                     cursor_y <= 12'd0; cursor_pos <= cursor_pos - Y_SPAN;
                   end
          4'b1000: if (cursor_x != X_MAX) begin
                     cursor_x <= cursor_x + 12'd1; cursor_pos <= cursor_pos + A_ONE;
                   end else if (WRAP_EN) begin
                     cursor_x <= 12'd0; cursor_pos <= cursor_pos - X_SPAN;
                   end
          default: ;
        endcase
      end
    end
  end
endmodule
